// File: rtl/encoder_onehot_pipe.sv
`default_nettype none
// ============================================================================
// encoder_onehot_pipe : registered one-hot / priority encoder, valid-ready
//                       on both sides, with a saturating multi-hot counter.
// Revision 1.0 : initial release
// ============================================================================
module encoder_onehot_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = $clog2(IN_W),
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  encoder_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] binary_out,
  output logic             hit,
  output logic             multi_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] binary_out_q, binary_out_d;
  logic             hit_q, hit_d;
  logic             multi_err_q, multi_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             w_any;
  logic             w_multi;
  logic [OUT_W-1:0] w_lo_idx;
  logic [OUT_W-1:0] w_hi_idx;
  logic [OUT_W-1:0] w_sel_idx;
  logic             w_sel_hit;
  logic             w_accept;
  logic             w_consume;
  logic [OUT_W-1:0] w_dec_idx;
  logic             w_dec_hit;
  logic             w_dec_err;

  // x & (x-1) clears the lowest set bit; anything left means multi-hot.
  always_comb begin
    w_any   = |encoder_in;
    w_multi = |(encoder_in & (encoder_in - IN_W'(1)));
  end

  always_comb begin
    w_lo_idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (encoder_in[i]) w_lo_idx = OUT_W'(i);
    end
  end

  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (encoder_in[i]) w_hi_idx = OUT_W'(i);
    end
  end

  generate
    if (MODE == 1) begin : g_mode_high
      assign w_sel_idx = w_hi_idx;
      assign w_sel_hit = 1'b1;
    end else if (MODE == 2) begin : g_mode_low
      assign w_sel_idx = w_lo_idx;
      assign w_sel_hit = 1'b1;
    end else begin : g_mode_strict
      assign w_sel_idx = '0;
      assign w_sel_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    w_dec_idx = '0;
    w_dec_hit = 1'b0;
    w_dec_err = 1'b0;
    if (enable && w_any) begin
      if (!w_multi) begin
        w_dec_idx = w_lo_idx;
        w_dec_hit = 1'b1;
      end else begin
        w_dec_idx = w_sel_idx;
        w_dec_hit = w_sel_hit;
        w_dec_err = 1'b1;
      end
    end
  end

  assign in_ready  = !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    binary_out_d = binary_out_q;
    hit_d        = hit_q;
    multi_err_d  = multi_err_q;
    if (w_accept) begin
      out_valid_d  = 1'b1;
      binary_out_d = w_dec_idx;
      hit_d        = w_dec_hit;
      multi_err_d  = w_dec_err;
    end else if (w_consume) begin
      out_valid_d  = 1'b0;
    end
  end

  // Counts at acceptance, independent of downstream; clear beats increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (w_accept && enable && w_multi && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      binary_out_q <= '0;
      hit_q        <= 1'b0;
      multi_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      binary_out_q <= binary_out_d;
      hit_q        <= hit_d;
      multi_err_q  <= multi_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign binary_out = binary_out_q;
  assign hit        = hit_q;
  assign multi_err  = multi_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/encoder_onehot_pipe.md
Name: encoder_onehot_pipe

Overview:
Parametrised, registered one-hot/priority encoder with valid/ready handshake on both sides. It converts an IN_W-bit request vector to a binary index, with three decode modes, a zero/hit indication and a multi-hot error flag. A saturating error counter sits alongside it. It replaces ad-hoc combinational encoders on paths that need a registered output and backpressure.

Parameters:
IN_W, 16, input vector width; legal values are 2..1024.
OUT_W, $clog2(IN_W), output index width; derived, do not override.
MODE, 0, decode mode. 0 = strict one-hot. 1 = priority, highest set bit wins. 2 = priority, lowest set bit wins.
CNT_W, 8, error counter width.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  decode enable; sampled with in_valid.
in_valid  input  1  the input vector is valid.
in_ready  output  1  the block can accept an input this cycle.
encoder_in  input  IN_W  request vector.
out_valid  output  1  the output register holds a result.
out_ready  input  1  the downstream stage accepts the result.
binary_out  output  OUT_W  encoded index.
hit  output  1  the result carries a valid index.
multi_err  output  1  more than one input bit was set.
err_cnt  output  CNT_W  saturating count of multi-hot inputs.
clr_cnt  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, binary_out=0, hit=0, multi_err=0, err_cnt=0. Reset overrides every other input in the same cycle. Reset mid-transfer drops the held result with no output.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and gives full throughput.
  - An input is accepted when in_valid && in_ready.
  - The output updates on the clock edge after acceptance, so latency is 1 cycle.
  - An output is consumed when out_valid && out_ready.
  - Hold rule: out_valid stays high and binary_out, hit and multi_err stay stable until the result is consumed.
  - Simultaneous consume and accept: the new result is loaded and out_valid stays 1.
  - Consume with no accept: out_valid drops to 0 on the next edge.
- Decode, evaluated at acceptance:
  - popcount(encoder_in) = 0, or enable = 0: binary_out=0, hit=0, multi_err=0.
  - Exactly one bit set at index k: binary_out=k and hit=1 in every mode.
  - More than one bit set:
    - multi_err=1 in every mode.
    - MODE 0: binary_out=0, hit=0.
    - MODE 1: binary_out = highest set index, hit=1.
    - MODE 2: binary_out = lowest set index, hit=1.
  - An input with only bit 0 set gives binary_out=0 with hit=1. hit is the only way to tell this from no-hit.
- Error counter:
  - Increments by 1 on each accepted input with enable=1 and multi-hot.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 sets err_cnt=0 on the next edge. Clear wins over a simultaneous increment.
  - err_cnt is independent of the out handshake: it counts at acceptance, not at consumption.
- No X propagation: the outputs hold their registered values when in_valid=0.

Test Plan:
1. Reset and basic decode. IN_W=16, MODE=0, out_ready=1. Apply reset for 2 cycles, then send 16'h0400 with enable=1. Required: all outputs 0 after reset; one cycle after acceptance out_valid=1, binary_out=10, hit=1, multi_err=0.
2. Sweep. Send each one-hot pattern 16'h0001..16'h8000 back to back with out_ready=1. Required: binary_out=0..15 on consecutive cycles, hit=1 throughout, in_ready=1 throughout.
3. Modes with multi-hot input 16'h0A00. Required: MODE 0 gives 0/hit=0/multi_err=1; MODE 1 gives 11/hit=1/multi_err=1; MODE 2 gives 9/hit=1/multi_err=1. err_cnt reads 1 in each build.
4. Backpressure. Send 16'h0004 with out_ready=0 for 3 cycles, while a second input 16'h0020 is offered with in_valid=1. Required: in_ready=0 while stalled; binary_out holds 2; after out_ready=1, binary_out=5 on the next cycle with no loss or duplication.
5. Disable and zero input. Send enable=0 with 16'h0008, then enable=1 with 16'h0000. Required: binary_out=0 and hit=0 for both, out_valid pulses for each, err_cnt unchanged.
6. Counter. CNT_W=2; send 5 multi-hot inputs. Required: err_cnt runs 1,2,3,3,3. Then assert clr_cnt together with a 6th multi-hot input. Required: err_cnt=0. Assert reset while out_valid=1 and out_ready=0. Required: out_valid=0 on the next edge.
